// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and helpers for the iterative mul/div sequencer
package muldiv_pkg;
    localparam int N_DEF = 32;
    localparam int CW = $clog2(N_DEF) + 1;

    typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} op_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

    // MULHU and REMU take their result from the upper accumulator, MUL and DIVU from the low register
    function automatic logic res_hi(input op_e op);
        return op[0];
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the core (master) and the mul/div sequencer (slave)
//   start/op/X/Y : request from the core
//   busy/done/result/div_zero : status and result back to the core
interface muldiv_if #(parameter int N = 32);
    import muldiv_pkg::*;
    logic         start;
    op_e          op;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         div_zero;
    modport master(output start, op, X, Y, input busy, done, result, div_zero);
    modport slave(input start, op, X, Y, output busy, done, result, div_zero);
endinterface

// File: rtl/Add_Subtractor_nb.sv
// Add_Subtractor_nb: N-bit adder/subtractor; Add_n=0 gives A+B, Add_n=1 gives A-B
//   A, B  : operands
//   Add_n : 0 add, 1 subtract (two's complement)
//   S     : sum/difference
//   C_OUT : carry out; for subtraction 1 means no borrow (A >= B)
module Add_Subtractor_nb #(parameter int N = 33) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Add_n,
    output logic [N-1:0] S,
    output logic         C_OUT
);
    assign {C_OUT, S} = {1'b0, A} + {1'b0, B ^ {N{Add_n}}} + {{N{1'b0}}, Add_n};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned MUL/MULHU/DIVU/REMU sharing one N+1-bit add/subtract datapath
//   clk, rst : clock and synchronous active-high reset
//   bus      : muldiv_if.slave (start/op/X/Y in, busy/done/result/div_zero out)
//   Optional macro MULDIV_FAST_DIV_EN: finish in one cycle for X<Y divides and zero-operand multiplies.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(N) + 1;

    state_e         state;
    op_e            op_r;
    logic [N-1:0]   xr;
    logic [N-1:0]   yr;
    logic [CNT_W-1:0] cnt;
    // acc is P_hi for multiply and R for divide; lo is P_lo / Q
    logic [N:0]     acc;
    logic [N-1:0]   lo;

    op_e            op_sel;
    logic [N:0]     add_a, add_b, add_s, mul_sum, acc_nx;
    logic [N-1:0]   lo_nx, res_nx;
    logic           add_n, add_c, to_fin, dz_nx;

    Add_Subtractor_nb #(.N(N + 1)) u_addsub (
        .A    (add_a),
        .B    (add_b),
        .Add_n(add_n),
        .S    (add_s),
        .C_OUT(add_c)
    );

    always_comb begin
        op_sel  = (state == S_IDLE) ? bus.op : op_r;
        add_a   = '0;
        add_b   = '0;
        add_n   = 1'b0;
        mul_sum = '0;
        acc_nx  = acc;
        lo_nx   = lo;
        to_fin  = 1'b0;
        dz_nx   = 1'b0;
        if (state == S_IDLE) begin
            acc_nx = '0;
            lo_nx  = is_div(bus.op) ? bus.X : bus.Y;
            // shortcuts preload acc/lo with the final values so the common result mux applies
            if (is_div(bus.op) && bus.Y == '0) begin
                acc_nx = {1'b0, bus.X};
                lo_nx  = '1;
                dz_nx  = 1'b1;
                to_fin = bus.start;
            end
`ifdef MULDIV_FAST_DIV_EN
            else if (is_div(bus.op) && bus.X < bus.Y) begin
                acc_nx = {1'b0, bus.X};
                lo_nx  = '0;
                to_fin = bus.start;
            end else if (!is_div(bus.op) && (bus.X == '0 || bus.Y == '0)) begin
                acc_nx = '0;
                lo_nx  = '0;
                to_fin = bus.start;
            end
`endif
        end else if (state == S_RUN) begin
            to_fin = (cnt == CNT_W'(1));
            if (is_div(op_r)) begin
                add_a  = {acc[N-1:0], lo[N-1]};
                add_b  = {1'b0, yr};
                add_n  = 1'b1;
                acc_nx = add_c ? add_s : add_a;
                lo_nx  = {lo[N-2:0], add_c};
            end else begin
                add_a   = acc;
                add_b   = {1'b0, xr};
                mul_sum = lo[0] ? add_s : acc;
                acc_nx  = {1'b0, mul_sum[N:1]};
                lo_nx   = {mul_sum[0], lo[N-1:1]};
            end
        end
        res_nx = res_hi(op_sel) ? acc_nx[N-1:0] : lo_nx;
    end

    // done/result are loaded on the edge entering FIN so they are visible during the FIN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_r         <= OP_MUL;
            xr           <= '0;
            yr           <= '0;
            cnt          <= '0;
            acc          <= '0;
            lo           <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    op_r         <= bus.op;
                    xr           <= bus.X;
                    yr           <= bus.Y;
                    acc          <= acc_nx;
                    lo           <= lo_nx;
                    cnt          <= CNT_W'(N);
                    bus.busy     <= 1'b1;
                    bus.div_zero <= 1'b0;
                    state        <= to_fin ? S_FIN : S_RUN;
                end
                S_RUN: begin
                    acc   <= acc_nx;
                    lo    <= lo_nx;
                    cnt   <= cnt - 1'b1;
                    state <= to_fin ? S_FIN : S_RUN;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
            if (to_fin) begin
                bus.result   <= res_nx;
                bus.done     <= 1'b1;
                bus.div_zero <= dz_nx;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer (N=32)
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef MULDIV_FAST_DIV_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 33;
`endif

    muldiv_if #(.N(32)) bus ();

    muldiv_sequencer #(.N(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // issue one request and check latency, busy window, single done pulse, result and div_zero
    task automatic run(input string tag, input op_e op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_res, input logic exp_dz, input int exp_lat);
        int lat;
        int busy_cnt;
        lat = -1;
        busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.X = x;
        bus.Y = y;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) lat = k;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, "_res"}, bus.result, exp_res);
        check({tag, "_dz"}, 32'(bus.div_zero), 32'(exp_dz));
        @(negedge clk);
        check({tag, "_post"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int lat;
        bus.start = 1'b0;
        bus.op = OP_MUL;
        bus.X = '0;
        bus.Y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_res", bus.result, 32'd0);
        check("rst_dz", 32'(bus.div_zero), 32'd0);

        run("mul", OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33);
        run("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        run("mul_wrap", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33);
        run("mulhu_s", OP_MULHU, 32'h8000_0000, 32'd4, 32'd2, 1'b0, 33);
        run("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        run("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        run("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33);
        run("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 33);
        run("divu_z", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        run("remu_z", OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 1);
        run("dz_clr", OP_DIVU, 32'd20, 32'd4, 32'd5, 1'b0, 33);
        run("divu_lt", OP_DIVU, 32'd3, 32'd10, 32'd0, 1'b0, FAST_LAT);
        run("remu_lt", OP_REMU, 32'd3, 32'd10, 32'd3, 1'b0, FAST_LAT);
        run("mul_zero", OP_MUL, 32'd0, 32'd5, 32'd0, 1'b0, FAST_LAT);

        // second start mid-operation must be dropped
        ndone = 0;
        lat = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = OP_MUL;
        bus.X = 32'd3;
        bus.Y = 32'd4;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            bus.start = (k == 10);
            if (k == 10) begin
                bus.X = 32'd9;
                bus.Y = 32'd9;
            end
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_res", bus.result, 32'd12);

        // reset mid-divide aborts without a done pulse
        ndone = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = OP_DIVU;
        bus.X = 32'd100;
        bus.Y = 32'd7;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) ndone++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (bus.done) ndone++;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_res", bus.result, 32'd0);
        check("abort_ndone", 32'(ndone), 32'd0);
        rst = 1'b0;
        run("div_after", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
